mem_writeback: RTL and testbench
================================

# mem_writeback

Writeback stage directly downstream of the memory-access stage. Accepts one retiring instruction per handshake, waits for the data-memory read response on loads, aligns and sign-/zero-extends load data, and drives the register-file write port. Non-load results (ALU, LUI, AUIPC, JAL/JALR link) pass through with one registered cycle. Misaligned loads, illegal load widths and response timeouts raise `err_o` and suppress the write.

## Interface
- `RESP_TIMEOUT`, 255: cycles to wait in WAIT_MEM before aborting the load. Legal range 1..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  instruction presented by the memory-access stage.
- `ready_o`  out  1  stage accepts; a transfer occurs when `valid_i & ready_o`.
- `opcode_i`  in  5  instr[6:2].
- `funct3_i`  in  3  load width/sign.
- `rd_i`  in  5  destination register.
- `alu_result_i`  in  32  ALU result; for loads, the byte address.
- `mem_rvalid_i`  in  1  read-data-valid pulse from data memory.
- `mem_rdata_i`  in  32  word-aligned read data, little-endian.
- `flush_i`  in  1  kill the in-flight or presented instruction.
- `rf_we_o`  out  1  register-file write enable, one-cycle pulse.
- `rf_waddr_o`  out  5  write address.
- `rf_wdata_o`  out  32  write data.
- `err_o`  out  1  one-cycle error pulse.

## Operation
- Writeback opcodes: 01100 OP, 00100 OP-IMM, 01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR. Write data is `alu_result_i`.
- Load opcode: 00000. All other opcodes (store, branch, system, etc.) retire with no write and no error.
- The write is always suppressed when rd = 0. The error path is unaffected by rd.
- FSM states: IDLE, WAIT_MEM.
- IDLE: `ready_o`=1. On a transfer with `flush_i`=0:
  - Writeback opcode: register the write; stay in IDLE.
  - Load with legal funct3 and aligned address: capture rd, funct3 and addr[1:0]; clear the timeout counter; go to WAIT_MEM.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]≠0: `err_o` pulse, no write, stay in IDLE.
- WAIT_MEM: `ready_o`=0.
  - On `mem_rvalid_i`: extract the data, register the write, go to IDLE.
  - Counter reaches `RESP_TIMEOUT`: `err_o` pulse, no write, go to IDLE.
- Load extraction: shift = addr[1:0]×8. LB (000) sign-extends bits [7:0] of the shifted word. LBU (100) zero-extends them. LH (001) and LHU (101) do the same on bits [15:0]. LW (010) passes the full word.
- `mem_rvalid_i` in IDLE is ignored.
- `flush_i`:
  - In IDLE, a presented instruction is discarded; no write, no error.
  - In WAIT_MEM, the load is aborted and the FSM returns to IDLE; no write, no error.
  - `mem_rvalid_i` or timeout in the same cycle as `flush_i` is dropped. Flush wins.
- Reset: state IDLE, counter 0, `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, `err_o`=0. `ready_o`=0 while `rst`=1 and 1 in the cycle after `rst` deasserts. Reset mid-WAIT_MEM abandons the load silently.

## Timing
- `rf_we_o`, `rf_waddr_o`, `rf_wdata_o` and `err_o` are registered.
- `ready_o` is combinational from state and `rst`.
- Non-load: transfer at edge N → `rf_we_o`=1 during cycle N+1, for one cycle.
- Load: transfer at N → earliest response at N+1 → write visible the cycle after `mem_rvalid_i`. Minimum load latency is 2 cycles. `ready_o` returns to 1 in the same cycle as the write.
- Timeout: `err_o` asserts in the cycle after WAIT_MEM has spanned `RESP_TIMEOUT` cycles.
- `rf_waddr_o` and `rf_wdata_o` hold their last values when `rf_we_o`=0.
- Throughput: one non-load per cycle; back-to-back loads are possible.

## Configuration
- `MEM_WB_TIMEOUT_EN` defined: the timeout counter and the abort path are compiled in as described.
- `MEM_WB_TIMEOUT_EN` undefined: no counter. WAIT_MEM exits only on `mem_rvalid_i`, `flush_i` or `rst`. `err_o` comes only from misalignment or illegal funct3. `RESP_TIMEOUT` is unused.

## Test plan
- OP-IMM: rd=5, alu=0x0000_1234 → next cycle `rf_we_o`=1, addr=5, data=0x0000_1234. Same with rd=0 → `rf_we_o` stays 0.
- LB at addr 0x103, rdata=0x80FF_0011, 2-cycle response → write 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x102 → 0x0000_80FF.
- LW at 0x101 → `err_o` pulse the next cycle, no write, `ready_o` stays 1. Load with funct3=011 → same response.
- LW with no response and `RESP_TIMEOUT`=4 → `ready_o`=0 for 4 cycles, then `err_o` pulse, no write. With the macro undefined → bench waits 20 cycles and sees `ready_o`=0 throughout.
- LW in WAIT_MEM with `flush_i` and `mem_rvalid_i` in the same cycle → no write, no error, IDLE the next cycle.
- `rst` asserted mid-WAIT_MEM with a response the following cycle → all outputs 0, response ignored, `ready_o`=1 after release.

Source files
------------

// File: rtl/mem_writeback.sv
// mem_writeback: writeback stage behind the memory-access stage.
// It retires non-load results one cycle after the handshake. For loads it
// waits for the data-memory response, then aligns and extends the data.
// Misaligned loads and illegal load widths raise err_o and skip the write.
// Optional feature: define MEM_WB_TIMEOUT_EN to compile in the response
// timeout counter and its abort path. It is left out by default.
module mem_writeback #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [4:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] alu_result_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        flush_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        err_o
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    // A timeout of zero cannot be counted, and the 16-bit counter tops out at 65535.
    if (RESP_TIMEOUT < 1 || RESP_TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_writeback: RESP_TIMEOUT out of range 1..65535");
    end

    state_t      r_state;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [4:0]  r_ldRd;
    logic [2:0]  r_ldFunct3;
    logic [1:0]  r_ldOffset;

    logic        w_isWriteback;
    logic        w_isLoad;
    logic        w_funct3Legal;
    logic        w_misaligned;
    logic        w_loadErr;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_loadData;

    assign ready_o    = (r_state == IDLE) && !rst;
    assign rf_we_o    = r_we;
    assign rf_waddr_o = r_waddr;
    assign rf_wdata_o = r_wdata;
    assign err_o      = r_err;

    assign w_isWriteback = (opcode_i == OPC_OP)    || (opcode_i == OPC_OP_IMM) ||
                           (opcode_i == OPC_LUI)   || (opcode_i == OPC_AUIPC)  ||
                           (opcode_i == OPC_JAL)   || (opcode_i == OPC_JALR);
    assign w_isLoad      = (opcode_i == OPC_LOAD);
    // Legal load widths are LB, LH, LW, LBU and LHU.
    assign w_funct3Legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                           (funct3_i == 3'b010) || (funct3_i == 3'b100) ||
                           (funct3_i == 3'b101);
    // Halfwords need an even address. Words need addr[1:0] == 0.
    assign w_misaligned  = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                           ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
    assign w_loadErr     = !w_funct3Legal || w_misaligned;

`ifdef MEM_WB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(RESP_TIMEOUT - 1);
    logic [15:0] r_count;
    assign w_timeout = (r_count == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Shift the little-endian word so the addressed byte lands in bits [7:0], then extend it by width.
    always_comb begin
        w_shifted  = mem_rdata_i >> {r_ldOffset, 3'b000};
        w_loadData = w_shifted;
        case (r_ldFunct3)
            3'b000:  w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_loadData = {24'b0, w_shifted[7:0]};
            3'b001:  w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_loadData = {16'b0, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    // FSM with registered write port and error pulse. Flush beats a response or timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_waddr    <= 5'd0;
            r_wdata    <= 32'd0;
            r_err      <= 1'b0;
            r_ldRd     <= 5'd0;
            r_ldFunct3 <= 3'd0;
            r_ldOffset <= 2'd0;
`ifdef MEM_WB_TIMEOUT_EN
            r_count    <= 16'd0;
`endif
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        if (w_isWriteback) begin
                            if (rd_i != 5'd0) begin
                                r_we    <= 1'b1;
                                r_waddr <= rd_i;
                                r_wdata <= alu_result_i;
                            end
                        end else if (w_isLoad) begin
                            if (w_loadErr) begin
                                r_err <= 1'b1;
                            end else begin
                                r_ldRd     <= rd_i;
                                r_ldFunct3 <= funct3_i;
                                r_ldOffset <= alu_result_i[1:0];
                                r_state    <= WAIT_MEM;
`ifdef MEM_WB_TIMEOUT_EN
                                r_count    <= 16'd0;
`endif
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                    end else if (mem_rvalid_i) begin
                        if (r_ldRd != 5'd0) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_ldRd;
                            r_wdata <= w_loadData;
                        end
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
`ifdef MEM_WB_TIMEOUT_EN
                        r_count <= r_count + 16'd1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback.sv
// Testbench for mem_writeback. A behavioural model checks every cycle.
// Directed cases pin literal values. Define MEM_WB_TIMEOUT_EN to
// exercise the timeout build.
module tb_mem_writeback;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validIn = 1'b0;
    logic        readyOut;
    logic [4:0]  opcodeIn = 5'd0;
    logic [2:0]  funct3In = 3'd0;
    logic [4:0]  rdIn = 5'd0;
    logic [31:0] aluIn = 32'd0;
    logic        rvalidIn = 1'b0;
    logic [31:0] rdataIn = 32'd0;
    logic        flushIn = 1'b0;
    logic        weOut;
    logic [4:0]  waddrOut;
    logic [31:0] wdataOut;
    logic        errOut;

    int checks = 0;
    int errors = 0;

    // Model state: pending load and expected registered outputs.
    bit          mBusy = 1'b0;
    logic [4:0]  mRd = 5'd0;
    logic [2:0]  mF3 = 3'd0;
    logic [1:0]  mOff = 2'd0;
    int          mWaited = 0;
    logic        eWe = 1'b0;
    logic [4:0]  eAddr = 5'd0;
    logic [31:0] eData = 32'd0;
    logic        eErr = 1'b0;

    always #5 clk = ~clk;

    mem_writeback #(.RESP_TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (validIn),
        .ready_o      (readyOut),
        .opcode_i     (opcodeIn),
        .funct3_i     (funct3In),
        .rd_i         (rdIn),
        .alu_result_i (aluIn),
        .mem_rvalid_i (rvalidIn),
        .mem_rdata_i  (rdataIn),
        .flush_i      (flushIn),
        .rf_we_o      (weOut),
        .rf_waddr_o   (waddrOut),
        .rf_wdata_o   (wdataOut),
        .err_o        (errOut)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isWriteback(input logic [4:0] op);
        return op inside {5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11011, 5'b11001};
    endfunction

    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] moved;
        logic [7:0]  b;
        logic [15:0] h;
        moved = word >> (int'(off) * 8);
        b = moved[7:0];
        h = moved[15:0];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'($signed(h));
            3'b101:  return 32'(h);
            default: return moved;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        bit legal;
        int size;
        eWe  = 1'b0;
        eErr = 1'b0;
        if (rst) begin
            mBusy = 1'b0;
            eAddr = 5'd0;
            eData = 32'd0;
        end else if (!mBusy) begin
            if (validIn && !flushIn) begin
                if (isWriteback(opcodeIn)) begin
                    if (rdIn != 5'd0) begin
                        eWe = 1'b1;
                        eAddr = rdIn;
                        eData = aluIn;
                    end
                end else if (opcodeIn == 5'b00000) begin
                    legal = funct3In inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                    size  = 1 << int'(funct3In[1:0]);
                    if (!legal || (int'(aluIn[1:0]) % size) != 0) begin
                        eErr = 1'b1;
                    end else begin
                        mBusy = 1'b1;
                        mRd = rdIn;
                        mF3 = funct3In;
                        mOff = aluIn[1:0];
                        mWaited = 0;
                    end
                end
            end
        end else begin
            if (flushIn) begin
                mBusy = 1'b0;
            end else if (rvalidIn) begin
                if (mRd != 5'd0) begin
                    eWe = 1'b1;
                    eAddr = mRd;
                    eData = loadValue(mF3, mOff, rdataIn);
                end
                mBusy = 1'b0;
            end else begin
`ifdef MEM_WB_TIMEOUT_EN
                mWaited++;
                if (mWaited == TB_TIMEOUT) begin
                    eErr = 1'b1;
                    mBusy = 1'b0;
                end
`endif
            end
        end
    endtask

    // Compare process: registered outputs just after each edge, ready_o mid-low-phase.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            checkValue("model_we", weOut, eWe);
            checkValue("model_waddr", waddrOut, eAddr);
            checkValue("model_wdata", wdataOut, eData);
            checkValue("model_err", errOut, eErr);
            @(negedge clk);
            #2;
            checkValue("model_ready", readyOut, (!mBusy && !rst));
        end
    end

    task automatic applyStimulus(input logic r, input logic v, input logic fl,
                                 input logic [4:0] op, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        rst = r;
        validIn = v;
        flushIn = fl;
        opcodeIn = op;
        funct3In = f3;
        rdIn = rd;
        aluIn = alu;
        rvalidIn = rv;
        rdataIn = rdata;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic checkOutput(input string name, input logic we, input logic [4:0] addr,
                               input logic [31:0] data, input logic err);
        @(posedge clk);
        #3;
        checkValue({name, "_we"}, weOut, we);
        checkValue({name, "_waddr"}, waddrOut, addr);
        checkValue({name, "_wdata"}, wdataOut, data);
        checkValue({name, "_err"}, errOut, err);
    endtask

    task automatic checkReady(input string name, input logic exp);
        #1;
        checkValue({name, "_ready"}, readyOut, exp);
    endtask

    initial begin
        int cyc;
        logic [4:0] opList [13];
        opList = '{5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11011, 5'b11001,
                   5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b11000, 5'b11100, 5'b00011};

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkReady("rst_held", 1'b0);
        checkOutput("rst", 1'b0, 5'd0, 32'd0, 1'b0);
        idleCycle();
        checkReady("rst_release", 1'b1);

        // OP-IMM write, hold, and rd=0 suppression
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00100, 3'd0, 5'd5, 32'h0000_1234, 1'b0, 32'd0);
        checkOutput("opimm", 1'b1, 5'd5, 32'h0000_1234, 1'b0);
        idleCycle();
        checkOutput("opimm_hold", 1'b0, 5'd5, 32'h0000_1234, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00100, 3'd0, 5'd0, 32'h0000_5678, 1'b0, 32'd0);
        checkOutput("opimm_rd0", 1'b0, 5'd5, 32'h0000_1234, 1'b0);

        // LB / LBU at 0x103, LHU at 0x102, response one cycle after the transfer
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b000, 5'd7, 32'h0000_0103, 1'b0, 32'd0);
        checkOutput("lb_wait", 1'b0, 5'd5, 32'h0000_1234, 1'b0);
        checkReady("lb_wait", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h80FF_0011);
        checkOutput("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
        checkReady("lb_done", 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b100, 5'd8, 32'h0000_0103, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h80FF_0011);
        checkOutput("lbu", 1'b1, 5'd8, 32'h0000_0080, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b101, 5'd11, 32'h0000_0102, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h80FF_0011);
        checkOutput("lhu", 1'b1, 5'd11, 32'h0000_80FF, 1'b0);

        // Misaligned LW and illegal funct3
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b010, 5'd12, 32'h0000_0101, 1'b0, 32'd0);
        checkOutput("lw_misalign", 1'b0, 5'd11, 32'h0000_80FF, 1'b1);
        checkReady("lw_misalign", 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b011, 5'd12, 32'h0000_0100, 1'b0, 32'd0);
        checkOutput("ld_f3_011", 1'b0, 5'd11, 32'h0000_80FF, 1'b1);
        checkReady("ld_f3_011", 1'b1);

        // No response: timeout or indefinite wait depending on build
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b010, 5'd9, 32'h0000_0100, 1'b0, 32'd0);
        checkOutput("to_start", 1'b0, 5'd11, 32'h0000_80FF, 1'b0);
        checkReady("to_start", 1'b0);
`ifdef MEM_WB_TIMEOUT_EN
        for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
            idleCycle();
            checkOutput("to_wait", 1'b0, 5'd11, 32'h0000_80FF, 1'b0);
            checkReady("to_wait", 1'b0);
        end
        idleCycle();
        checkOutput("to_err", 1'b0, 5'd11, 32'h0000_80FF, 1'b1);
        checkReady("to_err", 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            idleCycle();
            checkOutput("nto_wait", 1'b0, 5'd11, 32'h0000_80FF, 1'b0);
            checkReady("nto_wait", 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("nto_flush", 1'b0, 5'd11, 32'h0000_80FF, 1'b0);
        checkReady("nto_flush", 1'b1);
`endif

        // Flush and response together: flush wins
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b010, 5'd10, 32'h0000_0100, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 5'd0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("flush_rv", 1'b0, 5'd11, 32'h0000_80FF, 1'b0);
        checkReady("flush_rv", 1'b1);

        // Reset during WAIT_MEM, response arrives after reset
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 3'b010, 5'd13, 32'h0000_0200, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("rst_wait", 1'b0, 5'd0, 32'd0, 1'b0);
        checkReady("rst_wait", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h1234_5678);
        checkOutput("rst_after", 1'b0, 5'd0, 32'd0, 1'b0);
        checkReady("rst_after", 1'b1);

        // Randomized traffic checked by the model
        for (cyc = 0; cyc < 800; cyc++) begin
            logic [4:0] rOp;
            logic [4:0] rRd;
            rOp = opList[$urandom_range(0, 12)];
            rRd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) == 0,
                          rOp, 3'($urandom), rRd, $urandom,
                          $urandom_range(0, 9) < 4, $urandom);
        end
        idleCycle();
        idleCycle();
        @(posedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
